button_debouncer: RTL and testbench

//   Per-channel debouncer for the DE0 push-buttons/switches. Synchronises raw

---
 rtl/button_debouncer.sv | 198 +++++++++++++++++++
 tb/tb_button_debouncer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
//   Per-channel debouncer for the DE0 push-buttons/switches. Each raw pad input
//   goes through a two-flop synchroniser. A four-state FSM then accepts a level
//   change only after STABLE_CYCLES consecutive equal synchronised samples.
//   Every output comes from a flop, so there is no combinational path from
//   button_raw to any output.
//
//   Optional feature (macro DEBOUNCER_LONG_PRESS_EN):
//     A per-channel hold counter produces a one-cycle long_press pulse once a
//     debounced high level has been held for LONG_CYCLES cycles. Without the
//     macro the hold counters are not built and long_press is tied to 0.
//
// Ports
//   clk             system clock
//   async_reset     asynchronous reset, active-low
//   button_raw      raw pad inputs, active-high, asynchronous to clk
//   button_level    debounced level per channel
//   button_press    one-cycle pulse on an accepted 0->1 change
//   button_release  one-cycle pulse on an accepted 1->0 change
//   long_press      one-cycle pulse after LONG_CYCLES of held high level
// ----------------------------------------------------------------------------
module button_debouncer #(
    parameter int CHANNELS      = 3,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int CNT_WIDTH     = 20,
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int LONG_WIDTH    = 25
) (
    input  logic                clk,
    input  logic                async_reset,
    input  logic [CHANNELS-1:0] button_raw,
    output logic [CHANNELS-1:0] button_level,
    output logic [CHANNELS-1:0] button_press,
    output logic [CHANNELS-1:0] button_release,
    output logic [CHANNELS-1:0] long_press
);

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_CHK_HI = 2'd1,
        S_HIGH   = 2'd2,
        S_CHK_LO = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    // Out-of-range parameters elaborate an extra, clearly named net.
    // The counters would otherwise wrap or never reach their terminal value.
    if ((STABLE_CYCLES < 2) ||
        ((64'd1 << CNT_WIDTH) <= 64'(STABLE_CYCLES)) ||
        ((64'd1 << LONG_WIDTH) <= 64'(LONG_CYCLES))) begin : g_bad_params
        logic bad_params_s;
        assign bad_params_s = 1'b1;
    end

    logic [CHANNELS-1:0]  sync1_r;
    logic [CHANNELS-1:0]  sync2_r;
    state_t               state_r [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_r   [CHANNELS];
    logic [CHANNELS-1:0]  level_r;
    logic [CHANNELS-1:0]  press_r;
    logic [CHANNELS-1:0]  release_r;

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= button_raw;
            sync2_r <= sync1_r;
        end
    end

    // Per-channel debounce FSM with registered level and pulse outputs.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            level_r   <= '0;
            press_r   <= '0;
            release_r <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i] <= S_LOW;
                cnt_r[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                press_r[i]   <= 1'b0;
                release_r[i] <= 1'b0;
                case (state_r[i])
                    S_LOW: begin
                        if (sync2_r[i]) begin
                            state_r[i] <= S_CHK_HI;
                            cnt_r[i]   <= CNT_ONE;
                        end else begin
                            cnt_r[i]   <= '0;
                        end
                    end
                    S_CHK_HI: begin
                        if (!sync2_r[i]) begin
                            // Bounce: drop back silently.
                            state_r[i] <= S_LOW;
                            cnt_r[i]   <= '0;
                        end else if (cnt_r[i] == CNT_LAST) begin
                            state_r[i] <= S_HIGH;
                            cnt_r[i]   <= '0;
                            level_r[i] <= 1'b1;
                            press_r[i] <= 1'b1;
                        end else begin
                            cnt_r[i]   <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    S_HIGH: begin
                        if (!sync2_r[i]) begin
                            state_r[i] <= S_CHK_LO;
                            cnt_r[i]   <= CNT_ONE;
                        end else begin
                            cnt_r[i]   <= '0;
                        end
                    end
                    S_CHK_LO: begin
                        if (sync2_r[i]) begin
                            state_r[i] <= S_HIGH;
                            cnt_r[i]   <= '0;
                        end else if (cnt_r[i] == CNT_LAST) begin
                            state_r[i]   <= S_LOW;
                            cnt_r[i]     <= '0;
                            level_r[i]   <= 1'b0;
                            release_r[i] <= 1'b1;
                        end else begin
                            cnt_r[i]     <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r[i] <= S_LOW;
                        cnt_r[i]   <= '0;
                        level_r[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign button_level   = level_r;
    assign button_press   = press_r;
    assign button_release = release_r;

`ifdef DEBOUNCER_LONG_PRESS_EN
    localparam logic [LONG_WIDTH-1:0] HOLD_ONE  = LONG_WIDTH'(1);
    localparam logic [LONG_WIDTH-1:0] HOLD_LAST = LONG_WIDTH'(LONG_CYCLES - 1);
    localparam logic [LONG_WIDTH-1:0] HOLD_MAX  = LONG_WIDTH'(LONG_CYCLES);

    logic [LONG_WIDTH-1:0] hold_r [CHANNELS];
    logic [CHANNELS-1:0]   long_r;

    // Hold counter: cleared on the way into S_HIGH; counts in S_HIGH and S_CHK_LO.
    // It is cleared in S_CHK_HI, so a release bounce back to S_HIGH keeps the count.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            long_r <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                hold_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                long_r[i] <= 1'b0;
                case (state_r[i])
                    S_CHK_HI: begin
                        hold_r[i] <= '0;
                    end
                    S_HIGH, S_CHK_LO: begin
                        if (hold_r[i] == HOLD_LAST) begin
                            long_r[i] <= 1'b1;
                        end else begin
                            long_r[i] <= 1'b0;
                        end
                        // Saturating counter, so the pulse cannot repeat.
                        if (hold_r[i] != HOLD_MAX) begin
                            hold_r[i] <= hold_r[i] + HOLD_ONE;
                        end else begin
                            hold_r[i] <= hold_r[i];
                        end
                    end
                    default: begin
                        hold_r[i] <= hold_r[i];
                    end
                endcase
            end
        end
    end

    assign long_press = long_r;
`else
    assign long_press = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// ----------------------------------------------------------------------------
// tb_button_debouncer
//   Scoreboard bench for button_debouncer (STABLE_CYCLES=4, LONG_CYCLES=10).
//   Each test pushes the expected press/release events into exp_q as it drives
//   stimulus. The expected edge is computed from the documented latency: a raw
//   change driven after edge E gives its pulse after edge E+STABLE_CYCLES+2.
//   tick() records every pulse the DUT produces into obs_q and long_q. Each test
//   then compares the queues itself.
// ----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int CH   = 3;
    localparam int STAB = 4;
    localparam int LONG = 10;
    localparam int LAT  = STAB + 2;

    typedef struct packed {
        int       cyc;
        logic [2:0] p;
        logic [2:0] r;
    } ev_t;

    logic          clk = 1'b0;
    logic          async_reset;
    logic [CH-1:0] button_raw;
    logic [CH-1:0] button_level;
    logic [CH-1:0] button_press;
    logic [CH-1:0] button_release;
    logic [CH-1:0] long_press;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t long_q[$];
    ev_t got;
    ev_t want;
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    button_debouncer #(
        .CHANNELS     (CH),
        .STABLE_CYCLES(STAB),
        .CNT_WIDTH    (3),
        .LONG_CYCLES  (LONG),
        .LONG_WIDTH   (4)
    ) dut (
        .clk           (clk),
        .async_reset   (async_reset),
        .button_raw    (button_raw),
        .button_level  (button_level),
        .button_press  (button_press),
        .button_release(button_release),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    task automatic tick();
        ev_t ev;
        @(posedge clk);
        #1;
        cyc++;
        if ((button_press | button_release) !== 3'b000) begin
            ev.cyc = cyc; ev.p = button_press; ev.r = button_release;
            obs_q.push_back(ev);
        end
        if (long_press !== 3'b000) begin
            ev.cyc = cyc; ev.p = long_press; ev.r = 3'b000;
            long_q.push_back(ev);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic expect_ev(input int c, input logic [2:0] p, input logic [2:0] r);
        ev_t ev;
        ev.cyc = c; ev.p = p; ev.r = r;
        exp_q.push_back(ev);
    endtask

    task automatic test_reset();
        button_raw  = 3'b111;
        async_reset = 1'b0;
        ticks(3);
        n_tests++;
        if ({button_level, button_press, button_release, long_press} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 000", {button_level, button_press, button_release, long_press});
        end
        obs_q.delete();
        async_reset = 1'b1;
        expect_ev(cyc + LAT, 3'b111, 3'b000);
        ticks(10);
        n_tests++;
        if (button_level !== 3'b111) begin
            n_fail++; $display("FAIL reset_level: got %b, want 111", button_level);
        end
        button_raw = 3'b000;
        expect_ev(cyc + LAT, 3'b000, 3'b111);
        ticks(10);
        n_tests++;
        if (button_level !== 3'b000) begin
            n_fail++; $display("FAIL reset_level_low: got %b, want 000", button_level);
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL reset_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_event: got cyc=%0d press=%b release=%b, want cyc=%0d press=%b release=%b",
                         got.cyc, got.p, got.r, want.cyc, want.p, want.r);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        button_raw = 3'b001;
        ticks(3);
        button_raw = 3'b000;
        ticks(10);
        n_tests++;
        if (button_level !== 3'b000) begin
            n_fail++; $display("FAIL glitch_level: got %b, want 000", button_level);
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL glitch_count: got %0d events, want 0", obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_bounce();
        button_raw = 3'b010; tick();
        button_raw = 3'b000; tick();
        button_raw = 3'b010; tick();
        button_raw = 3'b000; tick();
        button_raw = 3'b010;
        expect_ev(cyc + LAT, 3'b010, 3'b000);
        ticks(10);
        button_raw = 3'b000; tick();
        button_raw = 3'b010; tick();
        button_raw = 3'b000;
        expect_ev(cyc + LAT, 3'b000, 3'b010);
        ticks(10);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bounce_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL bounce_event: got cyc=%0d press=%b release=%b, want cyc=%0d press=%b release=%b",
                         got.cyc, got.p, got.r, want.cyc, want.p, want.r);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_independent();
        button_raw = 3'b001;
        expect_ev(cyc + LAT, 3'b001, 3'b000);
        ticks(2);
        button_raw = 3'b101;
        expect_ev(cyc + LAT, 3'b100, 3'b000);
        ticks(10);
        n_tests++;
        if (button_level !== 3'b101) begin
            n_fail++; $display("FAIL indep_level: got %b, want 101", button_level);
        end
        button_raw = 3'b000;
        expect_ev(cyc + LAT, 3'b000, 3'b101);
        ticks(10);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL indep_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL indep_event: got cyc=%0d press=%b release=%b, want cyc=%0d press=%b release=%b",
                         got.cyc, got.p, got.r, want.cyc, want.p, want.r);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        button_raw = 3'b001;
        ticks(4);
        async_reset = 1'b0;
        tick();
        async_reset = 1'b1;
        n_tests++;
        if (button_level !== 3'b000 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL resetmid_abort: got level=%b events=%0d, want level=000 events=0", button_level, obs_q.size());
        end
        expect_ev(cyc + LAT, 3'b001, 3'b000);
        ticks(10);
        button_raw = 3'b000;
        expect_ev(cyc + LAT, 3'b000, 3'b001);
        ticks(10);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL resetmid_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL resetmid_event: got cyc=%0d press=%b release=%b, want cyc=%0d press=%b release=%b",
                         got.cyc, got.p, got.r, want.cyc, want.p, want.r);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_long_press();
        int   long_want_n;
        ev_t  lwant;
        long_q.delete();
        button_raw = 3'b001;
        expect_ev(cyc + LAT, 3'b001, 3'b000);
        lwant.cyc = cyc + LAT + LONG; lwant.p = 3'b001; lwant.r = 3'b000;
        ticks(20);
        button_raw = 3'b000;
        expect_ev(cyc + LAT, 3'b000, 3'b001);
        ticks(10);
`ifdef DEBOUNCER_LONG_PRESS_EN
        long_want_n = 1;
`else
        long_want_n = 0;
`endif
        n_tests++;
        if (long_q.size() != long_want_n) begin
            n_fail++; $display("FAIL long_count: got %0d pulses, want %0d", long_q.size(), long_want_n);
        end
        if (long_q.size() == 1 && long_want_n == 1) begin
            got = long_q.pop_front(); n_tests++;
            if (got !== lwant) begin
                n_fail++;
                $display("FAIL long_event: got cyc=%0d long=%b, want cyc=%0d long=%b", got.cyc, got.p, lwant.cyc, lwant.p);
            end
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL long_evcount: got %0d events, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL long_press_event: got cyc=%0d press=%b release=%b, want cyc=%0d press=%b release=%b",
                         got.cyc, got.p, got.r, want.cyc, want.p, want.r);
            end
        end
        obs_q.delete(); exp_q.delete(); long_q.delete();
    endtask

    initial begin
        button_raw  = 3'b111;
        async_reset = 1'b0;
        test_reset();
        test_glitch();
        test_bounce();
        test_independent();
        test_reset_mid();
        test_long_press();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
